// File: rtl/reset_sequencer.sv
// Releases STAGES downstream reset domains in index order after the PLL-lock reset.
// It reports all_ready or a fault. The optional retry-on-timeout is enabled by RESET_SEQ_RETRY_EN.
module reset_sequencer #(
    parameter int unsigned STAGES      = 4,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       restart,
    input  logic [STAGES-1:0]                          stage_ready,
    output logic [STAGES-1:0]                          stage_reset,
    output logic                                       all_ready,
    output logic                                       fault,
`ifdef RESET_SEQ_RETRY_EN
    output logic [1:0]                                 retry_count,
`endif
    output logic [(STAGES > 1 ? $clog2(STAGES) : 1)-1:0] fault_stage
);

    localparam int unsigned IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT > STAGE_DELAY) ? TIMEOUT : STAGE_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(STAGES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_DELAY,
        ST_WAIT,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAGES-1:0]  stage_reset_d;
    logic               all_ready_d;
    logic               fault_d;
    logic [IDX_W-1:0]   fault_stage_d;

    logic               ready_sel;
    logic [IDX_W-1:0]   lost_idx;
    logic               delay_done;
    logic               timed_out;
    logic               ready_lost;
    logic               restart_take;
    logic               retry_ok;

`ifdef RESET_SEQ_RETRY_EN
    logic [1:0]         retry_q, retry_d;
    assign retry_count = retry_q;
    assign retry_ok    = (retry_q != 2'd3);
`else
    assign retry_ok    = 1'b0;
`endif

    assign delay_done   = (cnt_q == DELAY_LAST);
    assign timed_out    = (cnt_q == TIMEOUT_LAST);
    assign ready_lost   = ~&stage_ready;
    assign restart_take = restart && ((state_q == ST_RUN) || (state_q == ST_FAULT));

    // Ready of the stage being waited on, and lowest-index stage that dropped ready.
    always_comb begin
        ready_sel = 1'b0;
        lost_idx  = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            if (IDX_W'(i) == idx_q) ready_sel = stage_ready[i];
            if (!stage_ready[i])    lost_idx  = IDX_W'(i);
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            idx_q       <= '0;
            cnt_q       <= '0;
            stage_reset <= '1;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= '0;
`ifdef RESET_SEQ_RETRY_EN
            retry_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            stage_reset <= stage_reset_d;
            all_ready   <= all_ready_d;
            fault       <= fault_d;
            fault_stage <= fault_stage_d;
`ifdef RESET_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (restart_take) begin
            state_d = ST_HOLD;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_d = ST_DELAY;
                    cnt_d   = '0;
                end
                ST_DELAY: begin
                    if (delay_done) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (ready_sel) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DELAY;
                            idx_d   = idx_q + IDX_W'(1);
                            cnt_d   = '0;
                        end
                    end else if (timed_out) begin
                        if (retry_ok) begin
                            state_d = ST_HOLD;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (ready_lost) state_d = ST_FAULT;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        stage_reset_d = stage_reset;
        all_ready_d   = all_ready;
        fault_d       = fault;
        fault_stage_d = fault_stage;
`ifdef RESET_SEQ_RETRY_EN
        retry_d       = retry_q;
`endif
        if (restart_take) begin
            stage_reset_d = '1;
            all_ready_d   = 1'b0;
            fault_d       = 1'b0;
            fault_stage_d = '0;
`ifdef RESET_SEQ_RETRY_EN
            retry_d       = 2'd0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    stage_reset_d = '1;
                end
                ST_DELAY: begin
                    if (delay_done) begin
                        for (int i = 0; i < int'(STAGES); i++) begin
                            if (IDX_W'(i) == idx_q) stage_reset_d[i] = 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ready_sel) begin
                        if (idx_q == IDX_LAST) begin
                            all_ready_d = 1'b1;
`ifdef RESET_SEQ_RETRY_EN
                            retry_d     = 2'd0;
`endif
                        end
                    end else if (timed_out) begin
                        stage_reset_d = '1;
                        if (retry_ok) begin
`ifdef RESET_SEQ_RETRY_EN
                            retry_d = retry_q + 2'd1;
`endif
                        end else begin
                            fault_d       = 1'b1;
                            all_ready_d   = 1'b0;
                            fault_stage_d = idx_q;
                        end
                    end
                end
                ST_RUN: begin
                    if (ready_lost) begin
                        stage_reset_d = '1;
                        all_ready_d   = 1'b0;
                        fault_d       = 1'b1;
                        fault_stage_d = lost_idx;
                    end
                end
                default: begin
                    stage_reset_d = stage_reset;
                end
            endcase
        end
    end

endmodule
